// File: rtl/mbist_pkg.sv
// Shared MBIST definitions: repair budget, detector state encoding and
// counter widths used by the error detector and the repair-address block.
package mbist_pkg;

   localparam int BIST_ERR_LIMIT = 4;
   localparam int ERR_CNT_WD     = 4;
   localparam int ERR_IDX_WD     = (BIST_ERR_LIMIT > 1) ? $clog2(BIST_ERR_LIMIT) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FAIL
   } bist_state_e;

endpackage

// File: rtl/mbist_err_detect_if.sv
// Read/compare bus between the MBIST pattern source and the error detector,
// plus the error report the detector hands on towards repair capture.
interface mbist_err_if #(
   parameter int ADDR_WD = 9,
   parameter int DATA_WD = 32
);
   logic               bist_rd_en;
   logic [ADDR_WD-1:0] bist_addr;
   logic [DATA_WD-1:0] bist_exp_data;
   logic [DATA_WD-1:0] mem_rdata;
   logic               Error;
   logic [ADDR_WD-1:0] ErrorAddr;
   logic [DATA_WD-1:0] ErrorSyn;

   modport master (
      output bist_rd_en, bist_addr, bist_exp_data, mem_rdata,
      input  Error, ErrorAddr, ErrorSyn
   );

   modport slave (
      input  bist_rd_en, bist_addr, bist_exp_data, mem_rdata,
      output Error, ErrorAddr, ErrorSyn
   );
endinterface

// File: rtl/mbist_err_dedup.sv
// Small address CAM of already-reported failing addresses. The entry being
// written this cycle is also matched so back-to-back repeats are suppressed.
module mbist_err_dedup
   import mbist_pkg::*;
#(
   parameter int ADDR_WD = 9
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  wr_en,
   input  logic [ERR_IDX_WD-1:0] wr_idx,
   input  logic [ADDR_WD-1:0]    wr_addr,
   input  logic [ADDR_WD-1:0]    lk_addr,
   output logic                  hit
);

   logic [BIST_ERR_LIMIT-1:0] ent_vld;
   logic [ADDR_WD-1:0]        ent_addr [BIST_ERR_LIMIT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ent_vld         <= '0;
      else if (clr)    ent_vld         <= '0;
      else if (wr_en)  ent_vld[wr_idx] <= 1'b1;
   end

   // NOTE: address storage carries no reset; ent_vld alone decides whether an entry is live.
   always_ff @(posedge clk) begin
      if (wr_en && !clr) ent_addr[wr_idx] <= wr_addr;
   end

   always_comb begin
      // NOTE: combinational blocks assign a default first so no path can infer a latch.
      hit = wr_en && !clr && (wr_addr == lk_addr);
      for (int i = 0; i < BIST_ERR_LIMIT; i++) begin
         if (ent_vld[i] && (ent_addr[i] == lk_addr)) hit = 1'b1;
      end
   end

endmodule

// File: rtl/mbist_err_detect.sv
// Aligns MBIST address/expected data to SRAM read latency, compares against
// read data and reports each unique failing address once per session.
module mbist_err_detect
   import mbist_pkg::*;
#(
   parameter int BIST_ADDR_WD = 9,
   parameter int BIST_DATA_WD = 32,
   parameter int BIST_RD_LAT  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  bist_run,
   mbist_err_if.slave            bus,
   output logic [ERR_CNT_WD-1:0] err_cnt,
   output logic                  bist_fail
);

   bist_state_e state_q, state_d;

   logic                    run_q;
   logic                    start;
   logic                    capture;
   logic                    cmp_vld;
   logic                    mismatch;
   logic                    hit;
   logic                    report;
   logic                    go_fail;
   logic [ERR_IDX_WD-1:0]   wr_idx_q;
   logic [BIST_RD_LAT-1:0]  pipe_vld;
   logic [BIST_ADDR_WD-1:0] pipe_addr [BIST_RD_LAT];
   logic [BIST_DATA_WD-1:0] pipe_exp  [BIST_RD_LAT];
   logic [BIST_ADDR_WD-1:0] cmp_addr;
   logic [BIST_DATA_WD-1:0] cmp_exp;

   assign start    = bist_run & ~run_q;
   // A read in the session-start cycle already belongs to the new session.
   assign capture  = bus.bist_rd_en & bist_run & (state_q != FAIL);
   assign cmp_addr = pipe_addr[BIST_RD_LAT-1];
   assign cmp_exp  = pipe_exp[BIST_RD_LAT-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q   <= 1'b0;
         state_q <= IDLE;
      end else begin
         run_q   <= bist_run;
         state_q <= state_d;
      end
   end

   // Dropping bist_run flushes every read still in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld <= '0;
      end else if (!bist_run) begin
         pipe_vld <= '0;
      end else begin
         pipe_vld[0] <= capture;
         for (int i = 1; i < BIST_RD_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
      end
   end

   always_ff @(posedge clk) begin
      pipe_addr[0] <= bus.bist_addr;
      pipe_exp[0]  <= bus.bist_exp_data;
      for (int i = 1; i < BIST_RD_LAT; i++) begin
         pipe_addr[i] <= pipe_addr[i-1];
         pipe_exp[i]  <= pipe_exp[i-1];
      end
   end

   always_comb begin
      state_d  = state_q;
      cmp_vld  = pipe_vld[BIST_RD_LAT-1] & bist_run & (state_q == RUN);
      mismatch = cmp_vld & (cmp_exp != bus.mem_rdata);
      report   = mismatch & ~hit & (err_cnt <  ERR_CNT_WD'(BIST_ERR_LIMIT));
      go_fail  = mismatch & ~hit & (err_cnt == ERR_CNT_WD'(BIST_ERR_LIMIT));
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (!bist_run) state_d = IDLE;
                  else if (go_fail) state_d = FAIL;
         FAIL:    if (!bist_run) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.Error     <= 1'b0;
         bus.ErrorAddr <= '0;
         bus.ErrorSyn  <= '0;
         err_cnt       <= '0;
         bist_fail     <= 1'b0;
         wr_idx_q      <= '0;
      end else begin
         bus.Error <= report;
         if (report) begin
            bus.ErrorAddr <= cmp_addr;
            wr_idx_q      <= err_cnt[ERR_IDX_WD-1:0];
         end
         if (start) begin
            bus.ErrorSyn <= '0;
            err_cnt      <= '0;
            bist_fail    <= 1'b0;
         end else begin
            if (report) begin
               bus.ErrorSyn <= cmp_exp ^ bus.mem_rdata;
               err_cnt      <= err_cnt + ERR_CNT_WD'(1);
            end
            if (go_fail) bist_fail <= 1'b1;
         end
      end
   end

   // The table is written from the registered report; its bypass covers the next compare.
   mbist_err_dedup #(
      .ADDR_WD (BIST_ADDR_WD)
   ) u_dedup (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (start),
      .wr_en   (bus.Error),
      .wr_idx  (wr_idx_q),
      .wr_addr (bus.ErrorAddr),
      .lk_addr (cmp_addr),
      .hit     (hit)
   );

endmodule

// File: doc/mbist_err_detect.md
Name: mbist_err_detect

Overview:
- Producer side of the MBIST error/repair interface: compares SRAM read data against expected pattern data and emits one-cycle Error pulses with ErrorAddr.
- These pulses feed the repair-address capture logic.
- Aligns address/expected data to SRAM read latency, suppresses duplicate reports of the same failing address, counts unique failures, and flags unrepairable memory once the repair budget is exhausted.
- Sits between the MBIST pattern FSM / SRAM read port and the repair-address block.

Parameters:
- BIST_ADDR_WD, 9, memory address width
- BIST_DATA_WD, 32, memory data width
- BIST_RD_LAT, 1, SRAM read latency in cycles (1..3)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- bist_run  input  1  level; rising edge starts a test session, low = idle
- bist_rd_en  input  1  read strobe issued to SRAM this cycle
- bist_addr  input  BIST_ADDR_WD  address of the read issued this cycle
- bist_exp_data  input  BIST_DATA_WD  expected data for the read issued this cycle
- mem_rdata  input  BIST_DATA_WD  SRAM read data, valid BIST_RD_LAT cycles after bist_rd_en
- Error  output  1  one-cycle pulse: new unique failing address
- ErrorAddr  output  BIST_ADDR_WD  failing address, valid when Error=1, held otherwise
- ErrorSyn  output  BIST_DATA_WD  XOR syndrome (exp ^ rdata) of last reported error
- err_cnt  output  4  number of unique errors reported this session
- bist_fail  output  1  sticky: more unique failures than BIST_ERR_LIMIT

Behaviour:
- Reset (rst_n=0, asynchronous): Error=0, ErrorAddr=0, ErrorSyn=0, err_cnt=0, bist_fail=0; pipeline valids cleared; dedup table entries invalidated; FSM=IDLE.
- FSM states:
  - IDLE -> RUN on bist_run rising edge. Entering RUN clears err_cnt, bist_fail, ErrorSyn and the dedup table.
  - RUN -> FAIL on the (BIST_ERR_LIMIT+1)th unique mismatch.
  - RUN/FAIL -> IDLE when bist_run=0.
  - Outputs err_cnt, bist_fail, ErrorAddr and ErrorSyn hold their values in IDLE until the next session start.
- Alignment pipeline: bist_rd_en, bist_addr and bist_exp_data are delayed BIST_RD_LAT stages. The compare stage uses the delayed triple together with mem_rdata.
- Mismatch = delayed valid & (delayed exp != mem_rdata).
- Error latency: Error is registered and asserts exactly BIST_RD_LAT+1 cycles after the bist_rd_en cycle.
- Dedup table: BIST_ERR_LIMIT entries of address + valid. A mismatch whose address matches a valid entry produces no Error pulse and no count change.
- Unique mismatch in RUN with err_cnt < BIST_ERR_LIMIT:
  - Error=1; ErrorAddr and ErrorSyn loaded.
  - Table entry[err_cnt] written; err_cnt increments.
- Unique mismatch in RUN with err_cnt == BIST_ERR_LIMIT: no Error pulse; bist_fail=1; state -> FAIL; err_cnt stays at BIST_ERR_LIMIT.
- FAIL: no further Error pulses; compares ignored.
- Back-to-back mismatches are supported at one per cycle, including the same address on consecutive cycles: the second must be deduped. The dedup lookup must see a table write from the previous cycle (bypass or write-before-compare).
- bist_run falls while reads are in flight: pipeline valids are flushed and pending reads never produce Error.
- bist_run rising in the same cycle as bist_rd_en: that read belongs to the new session.
- bist_rd_en while not in RUN is ignored.
- Width rules: err_cnt is 4 bits; BIST_ERR_LIMIT must be <= 15.

Decomposition:
- Shared package mbist_pkg holds:
  - BIST_ERR_LIMIT (shared with the repair-address block)
  - typedef enum {IDLE, RUN, FAIL} for the detector state
  - localparam ERR_CNT_WD=4
- One natural sub-module, mbist_err_dedup: address CAM of BIST_ERR_LIMIT entries with clear, write-at-index, and match output including same-cycle bypass.

Test Plan:
- BIST_RD_LAT=1, no mismatches over 512 reads -> Error never asserts; err_cnt=0; bist_fail=0.
- Read 0x010, exp 0xA5A5A5A5, rdata 0xA5A5A4A5 -> Error pulse 2 cycles after rd_en; ErrorAddr=0x010; ErrorSyn=0x00000100; err_cnt=1.
- Mismatch at 0x020 on two consecutive reads, then again 10 cycles later -> exactly one Error pulse; err_cnt=1.
- BIST_ERR_LIMIT=4, unique failures at 0x001..0x005 -> four Error pulses (0x001..0x004); fifth sets bist_fail=1 and produces no pulse; err_cnt=4.
- BIST_RD_LAT=3, mismatch read issued, then bist_run dropped 1 cycle later -> no Error pulse; the next session starts with err_cnt=0.
- rst_n asserted mid-session with err_cnt=2 -> all outputs 0 immediately; after release and a new bist_run, a repeat of a previously failing address reports again.
